// File: rtl/sync_fifo_ext_if.sv
// Handshake and status bundle between a FIFO and the logic that drives it.
// The master side pushes, pops and clears errors; the slave side is the FIFO.
interface sync_fifo_ext_if #(
    parameter int p_ADDRESS_WIDTH = 4,
    parameter int p_DATA_WIDTH    = 8
);
    logic                       i_WRITE_REQUEST;
    logic                       i_READ_REQUEST;
    logic [p_DATA_WIDTH-1:0]    i_INPUT;
    logic                       i_CLEAR_ERRORS;
    logic [p_DATA_WIDTH-1:0]    o_OUTPUT;
    logic                       o_OUTPUT_VALID;
    logic                       o_FIFO_EMPTY;
    logic                       o_FIFO_FULL;
    logic                       o_FIFO_ALMOST_EMPTY;
    logic                       o_FIFO_ALMOST_FULL;
    logic [p_ADDRESS_WIDTH:0]   o_FILL_COUNT;
    logic                       o_OVERFLOW;
    logic                       o_UNDERFLOW;

    modport master (
        output i_WRITE_REQUEST, i_READ_REQUEST, i_INPUT, i_CLEAR_ERRORS,
        input  o_OUTPUT, o_OUTPUT_VALID, o_FIFO_EMPTY, o_FIFO_FULL,
               o_FIFO_ALMOST_EMPTY, o_FIFO_ALMOST_FULL, o_FILL_COUNT,
               o_OVERFLOW, o_UNDERFLOW
    );

    modport slave (
        input  i_WRITE_REQUEST, i_READ_REQUEST, i_INPUT, i_CLEAR_ERRORS,
        output o_OUTPUT, o_OUTPUT_VALID, o_FIFO_EMPTY, o_FIFO_FULL,
               o_FIFO_ALMOST_EMPTY, o_FIFO_ALMOST_FULL, o_FILL_COUNT,
               o_OVERFLOW, o_UNDERFLOW
    );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO using all 2**p_ADDRESS_WIDTH entries, with registered status
// flags, exact fill count, sticky error flags and optional first-word-fall-through.
module sync_fifo_ext #(
    parameter int p_ADDRESS_WIDTH      = 4,
    parameter int p_DATA_WIDTH         = 8,
    parameter int p_ALMOST_FULL_LEVEL  = 12,
    parameter int p_ALMOST_EMPTY_LEVEL = 4,
    parameter int p_FWFT               = 0
) (
    input  logic               i_CLK,
    input  logic               i_RESET,
    sync_fifo_ext_if.slave     fifo_bus
);
    localparam int c_DEPTH = 2 ** p_ADDRESS_WIDTH;
    localparam logic [p_ADDRESS_WIDTH:0] c_CNT_ZERO = (p_ADDRESS_WIDTH+1)'(0);
    localparam logic [p_ADDRESS_WIDTH:0] c_CNT_ONE  = (p_ADDRESS_WIDTH+1)'(1);
    localparam logic [p_ADDRESS_WIDTH:0] c_CNT_FULL = (p_ADDRESS_WIDTH+1)'(c_DEPTH);
    localparam logic [p_ADDRESS_WIDTH:0] c_CNT_AF   = (p_ADDRESS_WIDTH+1)'(p_ALMOST_FULL_LEVEL);
    localparam logic [p_ADDRESS_WIDTH:0] c_CNT_AE   = (p_ADDRESS_WIDTH+1)'(p_ALMOST_EMPTY_LEVEL);
    localparam logic [p_ADDRESS_WIDTH-1:0] c_PTR_ONE = p_ADDRESS_WIDTH'(1);

    if (p_ALMOST_FULL_LEVEL < 1 || p_ALMOST_FULL_LEVEL > c_DEPTH) begin : g_bad_almost_full
        $error("sync_fifo_ext: p_ALMOST_FULL_LEVEL must lie in 1..2**p_ADDRESS_WIDTH");
    end
    if (p_ALMOST_EMPTY_LEVEL < 0 || p_ALMOST_EMPTY_LEVEL > c_DEPTH - 1) begin : g_bad_almost_empty
        $error("sync_fifo_ext: p_ALMOST_EMPTY_LEVEL must lie in 0..2**p_ADDRESS_WIDTH-1");
    end

    logic [p_DATA_WIDTH-1:0]    mem_r [c_DEPTH];
    logic [p_ADDRESS_WIDTH-1:0] wr_ptr_r;
    logic [p_ADDRESS_WIDTH-1:0] rd_ptr_r;
    logic [p_ADDRESS_WIDTH-1:0] rd_ptr_nxt_s;
    logic [p_ADDRESS_WIDTH:0]   count_r;
    logic [p_ADDRESS_WIDTH:0]   count_nxt_s;
    logic                       empty_r, full_r, almost_empty_r, almost_full_r;
    logic                       overflow_r, underflow_r, valid_r, valid_nxt_s;
    logic [p_DATA_WIDTH-1:0]    out_r, out_nxt_s;
    logic                       read_ok_s, write_ok_s;

    // Accept decisions, next count/pointer and next output word from pre-edge state
    always_comb begin
        read_ok_s    = fifo_bus.i_READ_REQUEST && !empty_r;
        write_ok_s   = fifo_bus.i_WRITE_REQUEST && (!full_r || read_ok_s);
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        out_nxt_s    = out_r;
        valid_nxt_s  = 1'b0;

        if (read_ok_s) begin
            rd_ptr_nxt_s = rd_ptr_r + c_PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({write_ok_s, read_ok_s})
            2'b10:   count_nxt_s = count_r + c_CNT_ONE;
            2'b01:   count_nxt_s = count_r - c_CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        // FWFT pre-loads the head word; a word landing on the new head is forwarded
        if (p_FWFT != 0) begin
            valid_nxt_s = (count_nxt_s != c_CNT_ZERO);
            if (write_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
                out_nxt_s = fifo_bus.i_INPUT;
            end else begin
                out_nxt_s = mem_r[rd_ptr_nxt_s];
            end
        end else begin
            valid_nxt_s = read_ok_s;
            if (read_ok_s) begin
                out_nxt_s = mem_r[rd_ptr_r];
            end else begin
                out_nxt_s = out_r;
            end
        end
    end

    // Storage array; contents deliberately survive reset
    always_ff @(posedge i_CLK) begin
        if (!i_RESET && write_ok_s) begin
            mem_r[wr_ptr_r] <= fifo_bus.i_INPUT;
        end
    end

    // Pointers, count, flags and output registers; flags track the post-edge count
    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            wr_ptr_r       <= '0;
            rd_ptr_r       <= '0;
            count_r        <= c_CNT_ZERO;
            empty_r        <= 1'b1;
            full_r         <= 1'b0;
            almost_empty_r <= 1'b1;
            almost_full_r  <= 1'b0;
            overflow_r     <= 1'b0;
            underflow_r    <= 1'b0;
            out_r          <= '0;
            valid_r        <= 1'b0;
        end else begin
            if (write_ok_s) begin
                wr_ptr_r <= wr_ptr_r + c_PTR_ONE;
            end
            rd_ptr_r       <= rd_ptr_nxt_s;
            count_r        <= count_nxt_s;
            empty_r        <= (count_nxt_s == c_CNT_ZERO);
            full_r         <= (count_nxt_s == c_CNT_FULL);
            almost_empty_r <= (count_nxt_s <= c_CNT_AE);
            almost_full_r  <= (count_nxt_s >= c_CNT_AF);
            out_r          <= out_nxt_s;
            valid_r        <= valid_nxt_s;
            // A new error in the clearing cycle wins over the clear
            if (fifo_bus.i_WRITE_REQUEST && !write_ok_s) begin
                overflow_r <= 1'b1;
            end else if (fifo_bus.i_CLEAR_ERRORS) begin
                overflow_r <= 1'b0;
            end
            if (fifo_bus.i_READ_REQUEST && !read_ok_s) begin
                underflow_r <= 1'b1;
            end else if (fifo_bus.i_CLEAR_ERRORS) begin
                underflow_r <= 1'b0;
            end
        end
    end

    assign fifo_bus.o_OUTPUT            = out_r;
    assign fifo_bus.o_OUTPUT_VALID      = valid_r;
    assign fifo_bus.o_FIFO_EMPTY        = empty_r;
    assign fifo_bus.o_FIFO_FULL         = full_r;
    assign fifo_bus.o_FIFO_ALMOST_EMPTY = almost_empty_r;
    assign fifo_bus.o_FIFO_ALMOST_FULL  = almost_full_r;
    assign fifo_bus.o_FILL_COUNT        = count_r;
    assign fifo_bus.o_OVERFLOW          = overflow_r;
    assign fifo_bus.o_UNDERFLOW         = underflow_r;
endmodule

// File: tb/tb_sync_fifo_ext.sv
// Bench for sync_fifo_ext: a standard-mode and an FWFT instance share one stimulus
// stream and are compared every cycle against a queue-based occupancy model.
module tb_sync_fifo_ext;
    localparam int c_DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] q[$];
    logic [7:0] m_out = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic       model_ready = 1'b0;

    sync_fifo_ext_if #(.p_ADDRESS_WIDTH(4), .p_DATA_WIDTH(8)) bus0 ();
    sync_fifo_ext_if #(.p_ADDRESS_WIDTH(4), .p_DATA_WIDTH(8)) bus1 ();

    assign bus0.i_WRITE_REQUEST = wr_req;
    assign bus0.i_READ_REQUEST  = rd_req;
    assign bus0.i_INPUT         = din;
    assign bus0.i_CLEAR_ERRORS  = clr;
    assign bus1.i_WRITE_REQUEST = wr_req;
    assign bus1.i_READ_REQUEST  = rd_req;
    assign bus1.i_INPUT         = din;
    assign bus1.i_CLEAR_ERRORS  = clr;

    sync_fifo_ext #(.p_ADDRESS_WIDTH(4), .p_DATA_WIDTH(8), .p_ALMOST_FULL_LEVEL(12),
                    .p_ALMOST_EMPTY_LEVEL(4), .p_FWFT(0))
        dut0 (.i_CLK(clk), .i_RESET(rst), .fifo_bus(bus0));

    sync_fifo_ext #(.p_ADDRESS_WIDTH(4), .p_DATA_WIDTH(8), .p_ALMOST_FULL_LEVEL(12),
                    .p_ALMOST_EMPTY_LEVEL(4), .p_FWFT(1))
        dut1 (.i_CLK(clk), .i_RESET(rst), .fifo_bus(bus1));

    initial forever #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endfunction

    // Advance the model by one clock edge using the inputs held across that edge
    task automatic model_update();
        logic rok;
        logic wok;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_out = 8'h00;
            m_valid = 1'b0;
            model_ready = 1'b1;
        end else begin
            rok = rd_req && (q.size() != 0);
            wok = wr_req && ((q.size() < c_DEPTH) || rok);
            m_valid = rok;
            if (rok) m_out = q.pop_front();
            if (wok) q.push_back(din);
            if (wr_req && !wok) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
            if (rd_req && !rok) m_unf = 1'b1;
            else if (clr) m_unf = 1'b0;
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [7:0] d,
                        input logic c, input logic rs);
        wr_req = w;
        rd_req = r;
        din    = d;
        clr    = c;
        rst    = rs;
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Per-cycle comparison of both instances against the model
    initial forever begin
        @(negedge clk);
        if (model_ready) begin
            chk("count0",   32'(bus0.o_FILL_COUNT),        32'(q.size()));
            chk("count1",   32'(bus1.o_FILL_COUNT),        32'(q.size()));
            chk("empty0",   32'(bus0.o_FIFO_EMPTY),        32'(q.size() == 0));
            chk("empty1",   32'(bus1.o_FIFO_EMPTY),        32'(q.size() == 0));
            chk("full0",    32'(bus0.o_FIFO_FULL),         32'(q.size() == c_DEPTH));
            chk("aempty0",  32'(bus0.o_FIFO_ALMOST_EMPTY), 32'(q.size() <= 4));
            chk("afull0",   32'(bus0.o_FIFO_ALMOST_FULL),  32'(q.size() >= 12));
            chk("ovf0",     32'(bus0.o_OVERFLOW),          32'(m_ovf));
            chk("unf0",     32'(bus0.o_UNDERFLOW),         32'(m_unf));
            chk("ovf1",     32'(bus1.o_OVERFLOW),          32'(m_ovf));
            chk("unf1",     32'(bus1.o_UNDERFLOW),         32'(m_unf));
            chk("std_out",  32'(bus0.o_OUTPUT),            32'(m_out));
            chk("std_vld",  32'(bus0.o_OUTPUT_VALID),      32'(m_valid));
            chk("fwft_vld", 32'(bus1.o_OUTPUT_VALID),      32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("fwft_out", 32'(bus1.o_OUTPUT), 32'(q[0]));
            end
        end
    end

    initial begin
        // Reset state
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_empty",  32'(bus0.o_FIFO_EMPTY), 32'd1);
        chk("rst_aempty", 32'(bus0.o_FIFO_ALMOST_EMPTY), 32'd1);
        chk("rst_full",   32'(bus0.o_FIFO_FULL), 32'd0);
        chk("rst_count",  32'(bus0.o_FILL_COUNT), 32'd0);
        chk("rst_out",    32'(bus0.o_OUTPUT), 32'd0);
        chk("rst_fwout",  32'(bus1.o_OUTPUT), 32'd0);
        chk("rst_fwvld",  32'(bus1.o_OUTPUT_VALID), 32'd0);

        // Fill to full with 0x01..0x10
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 8'(k), 1'b0, 1'b0);
            if (k == 1)  chk("fwft_first", 32'(bus1.o_OUTPUT), 32'h01);
            if (k == 4)  chk("aempty_at4", 32'(bus0.o_FIFO_ALMOST_EMPTY), 32'd1);
            if (k == 5)  chk("aempty_at5", 32'(bus0.o_FIFO_ALMOST_EMPTY), 32'd0);
            if (k == 11) chk("afull_at11", 32'(bus0.o_FIFO_ALMOST_FULL), 32'd0);
            if (k == 12) chk("afull_at12", 32'(bus0.o_FIFO_ALMOST_FULL), 32'd1);
            if (k == 15) chk("full_at15",  32'(bus0.o_FIFO_FULL), 32'd0);
        end
        chk("full_at16",  32'(bus0.o_FIFO_FULL), 32'd1);
        chk("count_16",   32'(bus0.o_FILL_COUNT), 32'd16);
        chk("model_16",   32'(q.size()), 32'd16);
        step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set",    32'(bus0.o_OVERFLOW), 32'd1);
        chk("count_keep", 32'(bus0.o_FILL_COUNT), 32'd16);

        // Drain in order
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
            chk("drain_data", 32'(bus0.o_OUTPUT), 32'(k));
            chk("drain_vld",  32'(bus0.o_OUTPUT_VALID), 32'd1);
            if (k == 11) chk("aempty_c5", 32'(bus0.o_FIFO_ALMOST_EMPTY), 32'd0);
            if (k == 12) chk("aempty_c4", 32'(bus0.o_FIFO_ALMOST_EMPTY), 32'd1);
        end
        chk("empty_end", 32'(bus0.o_FIFO_EMPTY), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("unf_set",   32'(bus0.o_UNDERFLOW), 32'd1);
        chk("out_hold",  32'(bus0.o_OUTPUT), 32'h10);
        chk("vld_low",   32'(bus0.o_OUTPUT_VALID), 32'd0);

        // Clear errors; then a new error in the clearing cycle wins
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("clr_ovf", 32'(bus0.o_OVERFLOW), 32'd0);
        chk("clr_unf", 32'(bus0.o_UNDERFLOW), 32'd0);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("set_wins", 32'(bus0.o_UNDERFLOW), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Simultaneous read+write when full and when empty
        for (int k = 0; k < 16; k++) step(1'b1, 1'b0, 8'(8'h20 + k), 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        chk("rw_full_cnt", 32'(bus0.o_FILL_COUNT), 32'd16);
        chk("rw_full_ovf", 32'(bus0.o_OVERFLOW), 32'd0);
        chk("rw_full_out", 32'(bus0.o_OUTPUT), 32'h20);
        for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("rw_last_out", 32'(bus0.o_OUTPUT), 32'h55);
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0);
        chk("rw_empty_unf", 32'(bus0.o_UNDERFLOW), 32'd1);
        chk("rw_empty_cnt", 32'(bus0.o_FILL_COUNT), 32'd1);
        chk("rw_empty_fw",  32'(bus1.o_OUTPUT), 32'h77);
        step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        chk("rw_pop_77", 32'(bus0.o_OUTPUT), 32'h77);

        // Pointer wrap
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 8'(8'h80 + 16 * pass + k), 1'b0, 1'b0);
            for (int k = 0; k < 10; k++) begin
                step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
                chk("wrap_data", 32'(bus0.o_OUTPUT), 32'(8'h80 + 16 * pass + k));
            end
        end
        chk("wrap_count", 32'(bus0.o_FILL_COUNT), 32'd0);

        // FWFT visibility without a read, then pop
        step(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        chk("fw_show",     32'(bus1.o_OUTPUT), 32'h3C);
        chk("fw_show_vld", 32'(bus1.o_OUTPUT_VALID), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("fw_hold",     32'(bus1.o_OUTPUT), 32'h3C);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("fw_pop_vld",  32'(bus1.o_OUTPUT_VALID), 32'd0);
        chk("fw_pop_empty", 32'(bus1.o_FIFO_EMPTY), 32'd1);

        // Reset mid-operation with a write pending
        for (int k = 0; k < 8; k++) step(1'b1, 1'b0, 8'(8'hA0 + k), 1'b0, 1'b0);
        chk("pre_rst_cnt", 32'(bus0.o_FILL_COUNT), 32'd8);
        step(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        chk("mid_rst_cnt",   32'(bus0.o_FILL_COUNT), 32'd0);
        chk("mid_rst_empty", 32'(bus0.o_FIFO_EMPTY), 32'd1);
        chk("mid_rst_fwvld", 32'(bus1.o_OUTPUT_VALID), 32'd0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("post_rst_cnt",  32'(bus0.o_FILL_COUNT), 32'd0);
        step(1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        chk("post_rst_data", 32'(bus0.o_OUTPUT), 32'h42);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_ext.md
Name: sync_fifo_ext

Overview:
Parametrised single-clock FIFO, next generation of the team's sync FIFO.
- All 2**p_ADDRESS_WIDTH entries usable.
- Programmable almost-full/almost-empty thresholds.
- Exact fill-count output and sticky overflow/underflow error flags.
- Selectable standard (registered-read) or first-word-fall-through (FWFT) output mode.
- Used as the general buffering element between datapath stages in one clock domain.

Parameters:
- p_ADDRESS_WIDTH, 4: log2 of depth; D = 2**p_ADDRESS_WIDTH.
- p_DATA_WIDTH, 8: word width.
- p_ALMOST_FULL_LEVEL, 12: o_FIFO_ALMOST_FULL asserted when count >= this. Legal range 1..D.
- p_ALMOST_EMPTY_LEVEL, 4: o_FIFO_ALMOST_EMPTY asserted when count <= this. Legal range 0..D-1.
- p_FWFT, 0: 0 = standard mode, 1 = first-word-fall-through.

Ports:
- i_CLK  in  1  clock, rising edge.
- i_RESET  in  1  synchronous, active-high reset.
- i_WRITE_REQUEST  in  1  push request.
- i_READ_REQUEST  in  1  pop request.
- i_INPUT  in  p_DATA_WIDTH  write data.
- i_CLEAR_ERRORS  in  1  clears sticky error flags.
- o_OUTPUT  out  p_DATA_WIDTH  read data.
- o_OUTPUT_VALID  out  1  o_OUTPUT holds valid data.
- o_FIFO_EMPTY  out  1  count == 0.
- o_FIFO_FULL  out  1  count == D.
- o_FIFO_ALMOST_EMPTY  out  1  count <= p_ALMOST_EMPTY_LEVEL.
- o_FIFO_ALMOST_FULL  out  1  count >= p_ALMOST_FULL_LEVEL.
- o_FILL_COUNT  out  p_ADDRESS_WIDTH+1  current occupancy, 0..D.
- o_OVERFLOW  out  1  sticky: a write was rejected.
- o_UNDERFLOW  out  1  sticky: a read was rejected.

Behaviour:
- Reset values:
  - Pointers and count = 0.
  - o_FIFO_EMPTY = 1, o_FIFO_ALMOST_EMPTY = 1 (o_FIFO_ALMOST_EMPTY follows its rule; 1 for any legal level since count = 0).
  - o_FIFO_FULL = 0, o_FIFO_ALMOST_FULL = 0.
  - o_FILL_COUNT = 0, o_OVERFLOW = 0, o_UNDERFLOW = 0, o_OUTPUT = 0, o_OUTPUT_VALID = 0.
  - Memory contents are not cleared.
  - Reset asserted mid-operation discards all contents the next edge; reset takes priority over every other input.
- Pointers: p_ADDRESS_WIDTH bits, wrap naturally D-1 -> 0. Occupancy is tracked in a p_ADDRESS_WIDTH+1-bit count, so full and empty are distinguishable.
- Accept rules, evaluated on pre-edge state:
  - read_ok = i_READ_REQUEST && !o_FIFO_EMPTY.
  - write_ok = i_WRITE_REQUEST && (!o_FIFO_FULL || read_ok).
- Simultaneous read and write:
  - When full: both accepted; count unchanged.
  - When empty: read rejected (underflow), write accepted; count becomes 1.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Status flags and o_FILL_COUNT are registered and reflect the post-edge count with no lag. Example: after the edge accepting the D-th write, o_FIFO_FULL = 1 in the same cycle o_FILL_COUNT = D.
- Errors:
  - Rejected write (i_WRITE_REQUEST && !write_ok) sets o_OVERFLOW; data is dropped, state unchanged.
  - Rejected read sets o_UNDERFLOW; o_OUTPUT holds, o_OUTPUT_VALID = 0.
  - i_CLEAR_ERRORS clears both flags next edge. If a new error occurs in the same cycle, set wins.
- Standard mode (p_FWFT = 0):
  - On read_ok, o_OUTPUT <= mem[rd_ptr] and o_OUTPUT_VALID <= 1 for exactly one cycle (read latency 1).
  - Otherwise o_OUTPUT holds and o_OUTPUT_VALID <= 0.
- FWFT mode (p_FWFT = 1):
  - o_OUTPUT = mem[rd_ptr] and o_OUTPUT_VALID = !o_FIFO_EMPTY at all times.
  - A word written into an empty FIFO is visible the cycle after the write edge.
  - read_ok acknowledges and pops the currently shown word; the next word (if any) is shown the following cycle.
- Elaboration fails (generate-time error) if either threshold is outside its legal range.

Test Plan:
1. Defaults, reset, then 16 writes 0x01..0x10 with no reads -> o_FIFO_ALMOST_FULL rises after the 12th write edge, o_FIFO_FULL = 1 and o_FILL_COUNT = 16 after the 16th; 17th write 0xAA -> dropped, o_OVERFLOW = 1, count stays 16.
2. From full, 16 reads (p_FWFT = 0) -> o_OUTPUT = 0x01..0x10 in order, each one cycle after its read with o_OUTPUT_VALID pulsed. o_FIFO_ALMOST_EMPTY rises when count reaches 4; o_FIFO_EMPTY = 1 after the last. Extra read -> o_UNDERFLOW = 1, o_OUTPUT holds 0x10.
3. Full FIFO, read and write 0x55 in the same cycle -> both accepted, count stays 16, no overflow. 0x55 emerges after the 16 older words. Empty FIFO with read+write 0x77 -> o_UNDERFLOW = 1, count = 1.
4. Pointer wrap: 10 writes, 10 reads, 10 writes, 10 reads with increasing data -> all 20 words returned in order; count returns to 0.
5. p_FWFT = 1, write 0x3C into empty -> next cycle o_OUTPUT = 0x3C, o_OUTPUT_VALID = 1 with no read. Then read -> o_OUTPUT_VALID = 0, o_FIFO_EMPTY = 1.
6. Errors set, then i_CLEAR_ERRORS for one cycle -> both flags clear. Write 8 words, assert i_RESET for one cycle with a write pending -> count 0, o_FIFO_EMPTY = 1, no write accepted.
